// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared data width, NOP encoding and fetch queue entry type.
package instruction_fetch_unit_pkg;
   localparam int DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
      logic                  filled;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of fetch entries; allocated at request, filled by responses, popped by decode.
module fetch_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  alloc,
   input  logic [DATA_WIDTH-1:0] alloc_pc,
   input  logic                  fill,
   input  logic [DATA_WIDTH-1:0] fill_data,
   input  logic                  pop,
   output logic                  full,
   output fetch_entry_t          head,
   output logic [PW:0]           unfilled
);
   fetch_entry_t q [DEPTH];
   logic [PW:0] rd_ptr, wr_ptr, fill_ptr;
   assign full = (wr_ptr - rd_ptr) == (PW+1)'(DEPTH);
   assign unfilled = wr_ptr - fill_ptr;
   always_comb begin
      head = q[rd_ptr[PW-1:0]];
      head.filled = head.filled && (rd_ptr != wr_ptr);
   end
   always_ff @(posedge clk) begin
      if (alloc) q[wr_ptr[PW-1:0]] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
      if (fill) begin
         q[fill_ptr[PW-1:0]].instr  <= fill_data;
         q[fill_ptr[PW-1:0]].filled <= 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill_ptr <= '0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill_ptr <= '0;
      end else begin
         if (alloc) wr_ptr <= wr_ptr + 1'b1;
         if (fill) fill_ptr <= fill_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, imem request/response handshake and redirect flushing around fetch_queue.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
   input  logic                  redirect_valid_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instruction_o,
   output logic [DATA_WIDTH-1:0] pc_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 4;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [CW-1:0] discard;
   logic full, req_fire, drop, fill;
   logic [PW:0] unfilled;
   fetch_entry_t head;
   assign imem_req_valid_o = rst_n && !full && !redirect_valid_i;
   assign req_fire = imem_req_valid_o && imem_req_ready_i;
   assign drop = imem_rsp_valid_i && discard != '0;
   assign fill = imem_rsp_valid_i && discard == '0 && !redirect_valid_i;
   assign imem_addr_o = fetch_pc;
   assign instr_valid_o = head.filled && !redirect_valid_i;
   assign instruction_o = instr_valid_o ? head.instr : NOP_INSTR;
   assign pc_o = instr_valid_o ? head.pc : '0;
   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid_i),
      .alloc     (req_fire),
      .alloc_pc  (fetch_pc),
      .fill      (fill),
      .fill_data (imem_rsp_data_i),
      .pop       (instr_valid_o && instr_ready_i),
      .full      (full),
      .head      (head),
      .unfilled  (unfilled)
   );
   // A response arriving with a redirect is dropped, consuming one of the words now owed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else begin
         if (redirect_valid_i) fetch_pc <= redirect_pc_i & ~DATA_WIDTH'(3);
         else if (req_fire) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
         if (redirect_valid_i) discard <= discard + CW'(unfilled) - CW'(imem_rsp_valid_i);
         else if (drop) discard <= discard - 1'b1;
      end
   end
   assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid_i && discard == '0 && unfilled == '0));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic checked against an epoch-based program-order model.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;
   localparam int DEPTH = 2;
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req_valid_o, imem_req_ready_i = 1'b0, imem_rsp_valid_i = 1'b0;
   logic redirect_valid_i = 1'b0, instr_valid_o, instr_ready_i = 1'b0;
   logic [31:0] imem_addr_o, imem_rsp_data_i = '0, redirect_pc_i = '0, instruction_o, pc_o;
   instruction_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i(imem_rsp_data_i), .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i), .instruction_o(instruction_o), .pc_o(pc_o)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] addr; int epoch; int due;} mreq_t;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} ins_t;
   mreq_t mq[$];
   ins_t avail[$];
   ins_t dut_pops[$];
   logic [31:0] dut_reqs[$];
   logic [31:0] m_pc;
   int checks = 0, errors = 0;
   int epoch, inflight, cyc, lat, last_due, first_valid;
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      imem_rsp_valid_i = 1'b0;
      redirect_valid_i = 1'b0;
      #1;
      chk("rst_req_valid", {31'b0, imem_req_valid_o}, 0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_instr_valid", {31'b0, instr_valid_o}, 0);
      chk("rst_instruction", instruction_o, 32'h13);
      chk("rst_pc", pc_o, 32'h0);
      mq.delete(); avail.delete(); dut_pops.delete(); dut_reqs.delete();
      m_pc = 32'h0; epoch = 0; inflight = 0; cyc = 0; last_due = -1; first_valid = -1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic cycle(input logic mr, input logic dr, input logic rv, input logic [31:0] rp);
      logic rsp, ev, erq;
      mreq_t m;
      int due;
      imem_req_ready_i = mr; instr_ready_i = dr; redirect_valid_i = rv; redirect_pc_i = rp;
      rsp = mq.size() > 0 && mq[0].due <= cyc;
      imem_rsp_valid_i = rsp;
      imem_rsp_data_i = rsp ? word_of(mq[0].addr) : $urandom;
      #1;
      ev = avail.size() > 0 && !rv;
      erq = (inflight + avail.size()) < DEPTH && !rv;
      chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, erq});
      chk("addr", imem_addr_o, m_pc);
      chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, ev});
      chk("instruction", instruction_o, ev ? avail[0].instr : NOP_INSTR);
      if (ev) chk("pc", pc_o, avail[0].pc);
      if (instr_valid_o && first_valid < 0) first_valid = cyc;
      if (instr_valid_o && dr) dut_pops.push_back('{pc_o, instruction_o});
      if (imem_req_valid_o && mr) dut_reqs.push_back(imem_addr_o);
      @(posedge clk);
      if (rsp) m = mq.pop_front();
      if (rv) begin
         epoch++; m_pc = rp & ~32'h3; avail.delete(); inflight = 0;
      end else begin
         if (ev && dr) void'(avail.pop_front());
         if (rsp && m.epoch == epoch) begin
            avail.push_back('{m.addr, word_of(m.addr)});
            inflight--;
         end
         if (erq && mr) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{m_pc, epoch, due});
            last_due = due; inflight++; m_pc += 32'h4;
         end
      end
      cyc++;
      @(negedge clk);
   endtask
   task automatic run(input int n, input logic mr, input logic dr);
      for (int i = 0; i < n; i++) cycle(mr, dr, 1'b0, 32'h0);
   endtask
   initial begin
      lat = 1;
      @(negedge clk);
      do_reset();
      run(12, 1, 1);
      chk("first_valid_cycle", first_valid, 2);
      chk("seq_req0", dut_reqs[0], 32'h0);
      chk("seq_req1", dut_reqs[1], 32'h4);
      chk("seq_req2", dut_reqs[2], 32'h8);
      chk("seq_pop0_pc", dut_pops[0].pc, 32'h0);
      chk("seq_pop1_pc", dut_pops[1].pc, 32'h4);
      chk("seq_pop1_instr", dut_pops[1].instr, word_of(32'h4));
      do_reset();
      run(6, 1, 0);
      chk("stall_nreq", dut_reqs.size(), 2);
      chk("stall_npop", dut_pops.size(), 0);
      run(4, 1, 1);
      chk("stall_pop0", dut_pops[0].pc, 32'h0);
      chk("stall_pop1", dut_pops[1].pc, 32'h4);
      chk("stall_req2", dut_reqs[2], 32'h8);
      lat = 3;
      do_reset();
      run(2, 1, 1);
      cycle(1, 1, 1, 32'h100);
      run(12, 1, 1);
      chk("lat3_pop0_pc", dut_pops[0].pc, 32'h100);
      chk("lat3_pop0_instr", dut_pops[0].instr, word_of(32'h100));
      chk("lat3_req2", dut_reqs[2], 32'h100);
      lat = 1;
      do_reset();
      run(2, 1, 1);
      chk("coinc_rsp_pending", {31'b0, mq.size() > 0 && mq[0].due <= cyc}, 1);
      cycle(1, 1, 1, 32'h102);
      chk("coinc_no_pop", dut_pops.size(), 0);
      run(6, 1, 1);
      chk("coinc_req2", dut_reqs[2], 32'h100);
      chk("coinc_pop0", dut_pops[0].pc, 32'h100);
      do_reset();
      cycle(1, 1, 1, 32'hFFFF_FFFC);
      run(8, 1, 1);
      chk("wrap_req0", dut_reqs[0], 32'hFFFF_FFFC);
      chk("wrap_req1", dut_reqs[1], 32'h0);
      chk("wrap_pop0", dut_pops[0].pc, 32'hFFFF_FFFC);
      chk("wrap_pop1", dut_pops[1].pc, 32'h0);
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) lat = $urandom_range(1, 4);
         cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 6,
               ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF));
      end
      lat = 1;
      do_reset();
      run(5, 1, 0);
      chk("full_valid", {31'b0, instr_valid_o}, 1);
      chk("full_nreq", dut_reqs.size(), 2);
      do_reset();
      run(6, 1, 1);
      chk("restart_req0", dut_reqs[0], 32'h0);
      chk("restart_pop0", dut_pops[0].pc, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
